// File: rtl/mips_bus_memory_responder_pkg.sv
// Shared types and bus widths for the MIPS CPU bus memory responder.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mips_bus_memory_responder_if.sv
// Avalon-style MIPS CPU bus: the CPU is the master, the memory responder the slave.
interface mips_bus_memory_responder_if;
    import mips_bus_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );

endinterface

// File: rtl/mips_bus_memory_responder_byte_ram.sv
// Word-organised memory with per-byte-lane write enables and asynchronous read.
module mips_bus_byte_ram
    import mips_bus_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic [BE_W-1:0]          we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_bus_memory_responder.sv
// Bus slave memory: wait-state FSM, address window decode, transfer statistics
// and a sticky out-of-window error flag around a byte-enabled RAM.
module mips_bus_memory_responder
    import mips_bus_pkg::*;
#(
    parameter int          WAIT_CYCLES   = 2,
    parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
    parameter int          DEPTH         = 256,
    parameter string       RAM_INIT_FILE = ""
) (
    input  logic                              clk,
    input  logic                              reset,
    mips_bus_memory_responder_if.slave        bus,
    output logic [31:0]                       rd_count,
    output logic [31:0]                       wr_count,
    output logic                              bus_error
);

    localparam int                WCNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WCNT_DONE = WCNT_W'(WAIT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [ADDR_W:0]   WIN_BYTES = 33'(DEPTH) << 2;

    bus_state_t        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]       rd_count_q, wr_count_q;
    logic              bus_error_q;

    logic              req;
    logic              is_wr;
    logic              complete;
    logic              in_range;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // A simultaneous read+write is treated purely as a write.
    assign req      = bus.read | bus.write;
    assign is_wr    = bus.write;
    assign complete = req && (wcnt_q == WCNT_DONE);

    // Compare the offset rather than BASE_ADDR + size so a window at the top of
    // the address space cannot overflow.
    assign offset   = bus.address - BASE_ADDR;
    assign in_range = (bus.address >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    assign bus.waitrequest = !reset || (req && !complete);
    assign bus.readdata    = (reset && complete && !is_wr && in_range) ? ram_rdata : '0;
    assign ram_we          = (reset && complete && is_wr && in_range) ? bus.byteenable : '0;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (req && !complete) begin
                    state_d = WAIT;
                    wcnt_d  = WCNT_ONE;
                end else begin
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                // Dropping the request mid-transfer abandons it without completion.
                if (!req || complete) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (complete) begin
                if (is_wr) wr_count_q <= wr_count_q + 32'd1;
                else       rd_count_q <= rd_count_q + 32'd1;
                if (!in_range) bus_error_q <= 1'b1;
            end
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign bus_error = bus_error_q;

    mips_bus_byte_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (RAM_INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (word_idx),
        .wdata_i (bus.writedata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_mips_bus_memory_responder.sv
// Directed bench for two responder instances (2 wait states and 0 wait states)
// checked every cycle against a transfer-level model plus literal expectations.
module tb_mips_bus_memory_responder;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    logic [31:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        wreq  [2];
    logic [31:0] rdc   [2];
    logic [31:0] wrc   [2];
    logic        berr  [2];

    mips_bus_memory_responder_if bus0 ();
    mips_bus_memory_responder_if bus1 ();

    assign bus0.address    = addr[0];
    assign bus0.read       = rd[0];
    assign bus0.write      = wr[0];
    assign bus0.writedata  = wdata[0];
    assign bus0.byteenable = be[0];
    assign rdata[0]        = bus0.readdata;
    assign wreq[0]         = bus0.waitrequest;
    assign bus1.address    = addr[1];
    assign bus1.read       = rd[1];
    assign bus1.write      = wr[1];
    assign bus1.writedata  = wdata[1];
    assign bus1.byteenable = be[1];
    assign rdata[1]        = bus1.readdata;
    assign wreq[1]         = bus1.waitrequest;

    mips_bus_memory_responder #(.WAIT_CYCLES(2), .BASE_ADDR(BASE), .DEPTH(256), .RAM_INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .rd_count(rdc[0]), .wr_count(wrc[0]), .bus_error(berr[0])
    );

    mips_bus_memory_responder #(.WAIT_CYCLES(0), .BASE_ADDR(BASE), .DEPTH(256), .RAM_INIT_FILE("")) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .rd_count(rdc[1]), .wr_count(wrc[1]), .bus_error(berr[1])
    );

    // Transfer-level model: a held request completes on its (wait+1)-th cycle.
    int          age   [2];
    logic [31:0] m_rdc [2];
    logic [31:0] m_wrc [2];
    logic        m_err [2];
    logic [31:0] mmem  [2][256];

    function automatic int wait_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit in_win(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && (off < 32'd1024);
    endfunction

    function automatic int widx(logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off[7:0]);
    endfunction

    function automatic bit done(int d);
        return (rd[d] || wr[d]) && (age[d] == wait_of(d));
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                age[d]   = 0;
                m_rdc[d] = 32'd0;
                m_wrc[d] = 32'd0;
                m_err[d] = 1'b0;
            end else if (done(d)) begin
                if (wr[d]) begin
                    m_wrc[d] = m_wrc[d] + 32'd1;
                    if (in_win(addr[d])) begin
                        for (int i = 0; i < 4; i++)
                            if (be[d][i]) mmem[d][widx(addr[d])][8*i +: 8] = wdata[d][8*i +: 8];
                    end
                end else begin
                    m_rdc[d] = m_rdc[d] + 32'd1;
                end
                if (!in_win(addr[d])) m_err[d] = 1'b1;
                age[d] = 0;
            end else if (rd[d] || wr[d]) begin
                age[d] = age[d] + 1;
            end else begin
                age[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic        e_wreq;
                logic [31:0] e_rdata;
                if (!reset) begin
                    e_wreq  = 1'b1;
                    e_rdata = 32'd0;
                    cmp($sformatf("d%0d rd_count", d), rdc[d], 32'd0);
                    cmp($sformatf("d%0d wr_count", d), wrc[d], 32'd0);
                    cmp($sformatf("d%0d bus_error", d), 32'(berr[d]), 32'd0);
                end else begin
                    e_wreq  = (rd[d] || wr[d]) && !done(d);
                    e_rdata = (done(d) && !wr[d] && in_win(addr[d])) ? mmem[d][widx(addr[d])] : 32'd0;
                    cmp($sformatf("d%0d rd_count", d), rdc[d], m_rdc[d]);
                    cmp($sformatf("d%0d wr_count", d), wrc[d], m_wrc[d]);
                    cmp($sformatf("d%0d bus_error", d), 32'(berr[d]), 32'(m_err[d]));
                end
                cmp($sformatf("d%0d waitrequest", d), 32'(wreq[d]), 32'(e_wreq));
                cmp($sformatf("d%0d readdata", d), rdata[d], e_rdata);
            end
        end
    end

    // Starts and ends one cycle-unit after a rising edge; returns completion data and cycle count.
    task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output logic [31:0] rv, output int n);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        n  = 0;
        rv = 32'hFFFF_FFFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (!wreq[d]) begin
                rv = rdata[d];
                break;
            end
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          n;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = BASE; wdata[d] = 32'd0; be[d] = 4'h0;
        end
        rd[0] = 1'b1; rd[1] = 1'b1;
        chk_en = 1'b1;

        // Held in reset with a read pending.
        repeat (2) @(negedge clk);
        cmp("reset waitrequest", 32'(wreq[0]), 32'd1);
        cmp("reset readdata", rdata[0], 32'd0);
        cmp("reset rd_count", rdc[0], 32'd0);
        @(posedge clk); #1;
        rd[0] = 1'b0; rd[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        cmp("idle waitrequest", 32'(wreq[0]), 32'd0);
        @(posedge clk); #1;

        // Two wait states.
        xfer(0, 1'b0, 1'b1, 32'hBFC00004, 32'hDEADBEEF, 4'hF, v, n);
        cmp("write cycles", 32'(n), 32'd3);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, v, n);
        cmp("read cycles", 32'(n), 32'd3);
        cmp("read data", v, 32'hDEADBEEF);
        cmp("wr_count 1", wrc[0], 32'd1);
        cmp("rd_count 1", rdc[0], 32'd1);

        xfer(0, 1'b0, 1'b1, 32'hBFC00004, 32'h11223344, 4'b0101, v, n);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, v, n);
        cmp("byteenable merge", v, 32'hDE22BE44);

        xfer(0, 1'b1, 1'b0, 32'h00000000, 32'd0, 4'h0, v, n);
        cmp("oob read cycles", 32'(n), 32'd3);
        cmp("oob read data", v, 32'd0);
        cmp("bus_error set", 32'(berr[0]), 32'd1);
        xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, v, n);
        cmp("bus_error sticky", 32'(berr[0]), 32'd1);

        xfer(0, 1'b1, 1'b1, 32'hBFC00008, 32'hCAFEF00D, 4'hF, v, n);
        cmp("rw both wr_count", wrc[0], 32'd3);
        cmp("rw both rd_count", rdc[0], 32'd4);
        xfer(0, 1'b1, 1'b0, 32'hBFC00008, 32'd0, 4'h0, v, n);
        cmp("rw both readback", v, 32'hCAFEF00D);

        // Request held across two back-to-back reads.
        rd[0] = 1'b1; addr[0] = 32'hBFC00008;
        repeat (6) @(posedge clk);
        #1 rd[0] = 1'b0;
        cmp("back-to-back rd_count", rdc[0], 32'd7);

        xfer(0, 1'b1, 1'b0, 32'hBFBFFFFC, 32'd0, 4'h0, v, n);
        cmp("below window data", v, 32'd0);

        // Reset after one wait cycle with the read still held.
        rd[0] = 1'b1; addr[0] = 32'hBFC00004;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n = 0;
        v = 32'hFFFF_FFFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (!wreq[0]) begin
                v = rdata[0];
                break;
            end
        end
        @(posedge clk); #1;
        rd[0] = 1'b0;
        cmp("post-reset cycles", 32'(n), 32'd3);
        cmp("memory retained", v, 32'hDE22BE44);
        cmp("post-reset rd_count", rdc[0], 32'd1);
        cmp("post-reset bus_error", 32'(berr[0]), 32'd0);

        // Request dropped during wait states completes nothing.
        rd[0] = 1'b1; addr[0] = 32'hBFC00008;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        @(posedge clk); #1;
        cmp("abandoned rd_count", rdc[0], 32'd1);
        xfer(0, 1'b1, 1'b0, 32'hBFC00008, 32'd0, 4'h0, v, n);
        cmp("after abandon cycles", 32'(n), 32'd3);
        cmp("after abandon data", v, 32'hCAFEF00D);

        // Zero wait states.
        xfer(1, 1'b0, 1'b1, 32'hBFC003FC, 32'h12345678, 4'hF, v, n);
        cmp("ws0 write cycles", 32'(n), 32'd1);
        xfer(1, 1'b1, 1'b0, 32'hBFC003FC, 32'd0, 4'h0, v, n);
        cmp("ws0 read cycles", 32'(n), 32'd1);
        cmp("ws0 top word", v, 32'h12345678);
        xfer(1, 1'b0, 1'b1, 32'hBFC00000, 32'hA5A5A5A5, 4'hF, v, n);
        xfer(1, 1'b0, 1'b1, 32'hBFC00400, 32'hFFFFFFFF, 4'hF, v, n);
        cmp("ws0 oob write error", 32'(berr[1]), 32'd1);
        cmp("ws0 wr_count", wrc[1], 32'd3);
        xfer(1, 1'b1, 1'b0, 32'hBFC00000, 32'd0, 4'h0, v, n);
        cmp("ws0 no alias write", v, 32'hA5A5A5A5);
        rd[1] = 1'b1; addr[1] = 32'hBFC003FC;
        repeat (3) @(posedge clk);
        #1 rd[1] = 1'b0;
        cmp("ws0 back-to-back rd_count", rdc[1], 32'd5);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
